exception_controller: RTL and testbench
=======================================

EXCEPTION_CONTROLLER -- requirements
Module: exception_controller

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, program-counter and vector width.
REQ-002 SHALL have parameter NUM_SRC, default 4, number of exception sources (bit 0 overflow, bit 1 undefined opcode).
REQ-003 SHALL have parameter VEC_BASE, default 32'h0000_0080, handler vector base address.
REQ-004 SHALL have parameter VEC_STRIDE, default 16, byte spacing between per-cause handler vectors.
REQ-005 SHALL have parameter CNT_WIDTH, default 8, width of the exception counter.
REQ-006 SHALL define clk  input  1  sole clock; the block uses one clock; all state updates on rising edge.
REQ-007 SHALL define rst  input  1  reset; asynchronous, active-high.
REQ-008 SHALL define instr_valid  input  1  instruction in commit stage is valid.
REQ-009 SHALL define src_req  input  NUM_SRC  per-source exception request, qualified by instr_valid.
REQ-010 SHALL define pc  input  PC_WIDTH  address of the committing instruction.
REQ-011 SHALL define eret  input  1  handler return strobe.
REQ-012 SHALL define exc_taken  output  1  one-cycle pulse when an exception is accepted.
REQ-013 SHALL define flush  output  1  pipeline flush request.
REQ-014 SHALL define cause  output  clog2(NUM_SRC)  index of the accepted source.
REQ-015 SHALL define epc  output  PC_WIDTH  captured faulting pc.
REQ-016 SHALL define handler_pc  output  PC_WIDTH  VEC_BASE + cause*VEC_STRIDE.
REQ-017 SHALL define in_handler  output  1  high while in HANDLER state.
REQ-018 SHALL define double_fault  output  1  sticky nested-exception flag.
REQ-019 SHALL define exc_count  output  CNT_WIDTH  accepted-exception count.

Function
REQ-020 SHALL implement FSM states IDLE, FLUSH, HANDLER.
REQ-021 SHALL, in IDLE with instr_valid=1 and src_req!=0, accept: capture cause = lowest set index, epc = pc, pulse exc_taken, go FLUSH next cycle.
REQ-022 SHALL ignore src_req when instr_valid=0.
REQ-023 SHALL assert flush combinationally in the acceptance cycle and for the whole FLUSH cycle (2 cycles total).
REQ-024 SHALL move FLUSH -> HANDLER unconditionally after one cycle.
REQ-025 SHALL hold cause and epc stable from acceptance until the next accepted exception.
REQ-026 SHALL, in HANDLER, return to IDLE on eret=1; eret in IDLE or FLUSH is ignored.
REQ-027 SHALL, on instr_valid & src_req!=0 in FLUSH or HANDLER, set double_fault and not alter cause, epc or exc_count.
REQ-028 SHALL give eret priority over a simultaneous request in HANDLER: return to IDLE, no double_fault; request reissued the following cycle is accepted.
REQ-029 SHALL increment exc_count on each acceptance, saturating at all-ones.
REQ-030 SHALL clear double_fault only by reset.
REQ-031 SHALL compute handler_pc modulo 2^PC_WIDTH.

Reset
REQ-032 SHALL, on rst=1, immediately force state IDLE, exc_taken=0, flush=0, cause=0, epc=0, in_handler=0, double_fault=0, exc_count=0.
REQ-033 SHALL abandon any in-progress FLUSH or HANDLER on reset; no pulses after release until a new request.

Structure
REQ-034 SHALL place FSM state encoding, source-index constants (SRC_OVF=0, SRC_UNDEF_OP=1) and default VEC_BASE in shared package exc_pkg.
REQ-035 SHALL implement the lowest-index selection in sub-module exc_priority_enc (parametrised by NUM_SRC).

Verification
REQ-036 SHALL cover: src_req=4'b0001, pc=0x100 -> exc_taken 1 cycle, cause=0, epc=0x100, handler_pc=0x80, flush 2 cycles.
REQ-037 SHALL cover: src_req=4'b0110, pc=0x204 -> cause=1, handler_pc=0x90, exc_count=1.
REQ-038 SHALL cover: src_req=4'b0010 with instr_valid=0 -> no exc_taken, state IDLE.
REQ-039 SHALL cover: request during HANDLER -> double_fault=1, epc unchanged; eret+request same cycle -> IDLE, no double_fault.
REQ-040 SHALL cover: rst asserted mid-FLUSH -> all outputs 0 asynchronously; 256 acceptances with CNT_WIDTH=8 -> exc_count holds 255.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller: FSM encoding, source
// indices and the default handler vector base.
package exc_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_HANDLER = 2'd2;

  localparam int SRC_OVF      = 0;
  localparam int SRC_UNDEF_OP = 1;

  localparam logic [31:0] VEC_BASE_DEFAULT = 32'h0000_0080;

endpackage

// File: rtl/exc_priority_enc.sv
// Lowest-index-wins priority encoder over the exception request vector.
module exc_priority_enc
  import exc_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  // Scanning downward lets the lowest set bit overwrite higher ones,
  // so SRC_OVF always wins over SRC_UNDEF_OP when both are raised.
  always_comb begin
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
    any = |req;
  end

endmodule

// File: rtl/exception_controller.sv
// Commit-stage exception controller: accepts one exception at a time,
// flushes the pipeline for two cycles and tracks the handler until eret.
module exception_controller
  import exc_pkg::*;
#(
  parameter  int                  PC_WIDTH   = 32,
  parameter  int                  NUM_SRC    = 4,
  parameter  logic [PC_WIDTH-1:0] VEC_BASE   = PC_WIDTH'(VEC_BASE_DEFAULT),
  parameter  int                  VEC_STRIDE = 16,
  parameter  int                  CNT_WIDTH  = 8,
  localparam int                  IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 eret,
  output logic                 exc_taken,
  output logic                 flush,
  output logic [IDX_W-1:0]     cause,
  output logic [PC_WIDTH-1:0]  epc,
  output logic [PC_WIDTH-1:0]  handler_pc,
  output logic                 in_handler,
  output logic                 double_fault,
  output logic [CNT_WIDTH-1:0] exc_count
);

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     cause_q, cause_d;
  logic [PC_WIDTH-1:0]  epc_q, epc_d;
  logic                 dfault_q, dfault_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 accept;
  logic                 req_any;
  logic [IDX_W-1:0]     req_idx;
  logic                 req_hit;

  exc_priority_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .req (src_req),
    .any (req_any),
    .idx (req_idx)
  );

  assign req_hit = instr_valid & req_any;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    dfault_d = dfault_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_hit) begin
          accept  = 1'b1;
          state_d = ST_FLUSH;
          cause_d = req_idx;
          epc_d   = pc;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_FLUSH: begin
        state_d = ST_HANDLER;
        if (req_hit) dfault_d = 1'b1;
      end
      ST_HANDLER: begin
        // eret wins: a request in the same cycle is dropped, not a nested fault.
        if (eret)         state_d  = ST_IDLE;
        else if (req_hit) dfault_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cause_q  <= '0;
      epc_q    <= '0;
      dfault_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      dfault_q <= dfault_d;
      cnt_q    <= cnt_d;
    end
  end

  // Combinational outputs are gated by rst so they drop the instant reset rises.
  assign exc_taken    = accept & ~rst;
  assign flush        = (accept | (state_q == ST_FLUSH)) & ~rst;
  assign in_handler   = (state_q == ST_HANDLER);
  assign cause        = cause_q;
  assign epc          = epc_q;
  assign double_fault = dfault_q;
  assign exc_count    = cnt_q;
  assign handler_pc   = VEC_BASE + PC_WIDTH'(cause_q) * PC_WIDTH'(VEC_STRIDE);

endmodule

// File: tb/tb_exception_controller.sv
// Self-checking bench for exception_controller: per-scenario tasks plus a
// scoreboard of expected cause/epc/handler_pc/count per accepted exception.
module tb_exception_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [3:0]  src_req;
  logic [31:0] pc;
  logic        eret;
  logic        exc_taken;
  logic        flush;
  logic [1:0]  cause;
  logic [31:0] epc;
  logic [31:0] handler_pc;
  logic        in_handler;
  logic        double_fault;
  logic [7:0]  exc_count;

  exception_controller dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .src_req      (src_req),
    .pc           (pc),
    .eret         (eret),
    .exc_taken    (exc_taken),
    .flush        (flush),
    .cause        (cause),
    .epc          (epc),
    .handler_pc   (handler_pc),
    .in_handler   (in_handler),
    .double_fault (double_fault),
    .exc_count    (exc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] epc;
    logic [31:0] hpc;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;
  bit   pend = 1'b0;

  // Reference model for one acceptance: lowest set bit, vector address, saturating count.
  task automatic push_exp(input logic [3:0] req, input logic [31:0] p);
    exp_t e;
    int   idx;
    idx = 0;
    for (int i = 3; i >= 0; i--) if (req[i]) idx = i;
    if (exp_cnt < 255) exp_cnt++;
    e.cause = 2'(idx);
    e.epc   = p;
    e.hpc   = 32'h0000_0080 + 32'(idx) * 32'd16;
    e.cnt   = 8'(exp_cnt);
    sb.push_back(e);
  endtask

  // Registered results appear the cycle after exc_taken; compare them then.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_accept: got cause=%0d epc=%h, expected no acceptance", cause, epc);
        end else begin
          e = sb.pop_front();
          if (cause !== e.cause || epc !== e.epc || handler_pc !== e.hpc || exc_count !== e.cnt) begin
            bad++;
            $display("FAIL sb_accept: got cause=%0d epc=%h hpc=%h cnt=%0d, expected cause=%0d epc=%h hpc=%h cnt=%0d",
                     cause, epc, handler_pc, exc_count, e.cause, e.epc, e.hpc, e.cnt);
          end
        end
      end
      pend = exc_taken;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    instr_valid = 1'b0;
    src_req     = 4'b0000;
    eret        = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    pc  = '0;
    rst = 1'b1;
    step();
    step();
    rst     = 1'b0;
    exp_cnt = 0;
  endtask

  // Full accept -> FLUSH -> HANDLER -> eret sequence; leaves the DUT in IDLE.
  task automatic run_exc(input logic [3:0] req, input logic [31:0] p);
    step();
    instr_valid = 1'b1;
    src_req     = req;
    pc          = p;
    push_exp(req, p);
    step();
    clear_in();
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
  endtask

  task automatic test_reset();
    clear_in();
    pc  = 32'h0;
    rst = 1'b1;
    #1;
    total++;
    if ({exc_taken, flush, cause, epc, in_handler, double_fault, exc_count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got taken=%b flush=%b cause=%0d epc=%h inh=%b df=%b cnt=%0d, expected all 0",
               exc_taken, flush, cause, epc, in_handler, double_fault, exc_count);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (handler_pc !== 32'h80) begin
      bad++;
      $display("FAIL reset_handler_pc: got %h, expected 00000080", handler_pc);
    end
  endtask

  task automatic test_basic();
    step();
    instr_valid = 1'b1;
    src_req     = 4'b0001;
    pc          = 32'h100;
    push_exp(4'b0001, 32'h100);
    @(negedge clk);
    total++;
    if (exc_taken !== 1'b1 || flush !== 1'b1) begin
      bad++;
      $display("FAIL basic_accept_cycle: got taken=%b flush=%b, expected 1 1", exc_taken, flush);
    end
    step();
    clear_in();
    @(negedge clk);
    total++;
    if (exc_taken !== 1'b0 || flush !== 1'b1 || in_handler !== 1'b0) begin
      bad++;
      $display("FAIL basic_flush_cycle: got taken=%b flush=%b inh=%b, expected 0 1 0", exc_taken, flush, in_handler);
    end
    step();
    @(negedge clk);
    total++;
    if (flush !== 1'b0 || in_handler !== 1'b1 || handler_pc !== 32'h80) begin
      bad++;
      $display("FAIL basic_handler: got flush=%b inh=%b hpc=%h, expected 0 1 00000080", flush, in_handler, handler_pc);
    end
    eret = 1'b1;
    step();
    eret = 1'b0;
    @(negedge clk);
    total++;
    if (in_handler !== 1'b0 || exc_taken !== 1'b0) begin
      bad++;
      $display("FAIL basic_eret: got inh=%b taken=%b, expected 0 0", in_handler, exc_taken);
    end
  endtask

  task automatic test_cause1();
    do_reset();
    step();
    instr_valid = 1'b1;
    src_req     = 4'b0110;
    pc          = 32'h204;
    push_exp(4'b0110, 32'h204);
    step();
    clear_in();
    @(negedge clk);
    total++;
    if (cause !== 2'd1 || epc !== 32'h204 || handler_pc !== 32'h90 || exc_count !== 8'd1) begin
      bad++;
      $display("FAIL cause1: got cause=%0d epc=%h hpc=%h cnt=%0d, expected 1 00000204 00000090 1",
               cause, epc, handler_pc, exc_count);
    end
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
  endtask

  task automatic test_invalid();
    step();
    instr_valid = 1'b0;
    src_req     = 4'b0010;
    pc          = 32'h500;
    @(negedge clk);
    total++;
    if (exc_taken !== 1'b0 || flush !== 1'b0) begin
      bad++;
      $display("FAIL invalid_no_take: got taken=%b flush=%b, expected 0 0", exc_taken, flush);
    end
    step();
    @(negedge clk);
    total++;
    if (in_handler !== 1'b0 || flush !== 1'b0 || exc_count !== 8'(exp_cnt) || epc !== 32'h204) begin
      bad++;
      $display("FAIL invalid_idle: got inh=%b flush=%b cnt=%0d epc=%h, expected 0 0 %0d 00000204",
               in_handler, flush, exc_count, exp_cnt, epc);
    end
    clear_in();
  endtask

  task automatic test_double_fault();
    do_reset();
    step();
    instr_valid = 1'b1;
    src_req     = 4'b0001;
    pc          = 32'h300;
    push_exp(4'b0001, 32'h300);
    step();
    clear_in();
    step();
    instr_valid = 1'b1;
    src_req     = 4'b0010;
    pc          = 32'h444;
    @(negedge clk);
    total++;
    if (exc_taken !== 1'b0 || double_fault !== 1'b0) begin
      bad++;
      $display("FAIL df_no_take: got taken=%b df=%b, expected 0 0", exc_taken, double_fault);
    end
    step();
    clear_in();
    @(negedge clk);
    total++;
    if (double_fault !== 1'b1 || epc !== 32'h300 || cause !== 2'd0 || exc_count !== 8'd1 || in_handler !== 1'b1) begin
      bad++;
      $display("FAIL df_set: got df=%b epc=%h cause=%0d cnt=%0d inh=%b, expected 1 00000300 0 1 1",
               double_fault, epc, cause, exc_count, in_handler);
    end
    eret = 1'b1;
    step();
    eret = 1'b0;
    @(negedge clk);
    total++;
    if (double_fault !== 1'b1) begin
      bad++;
      $display("FAIL df_sticky: got df=%b, expected 1", double_fault);
    end

    // eret and a request in the same HANDLER cycle: eret wins, request retried next.
    do_reset();
    step();
    instr_valid = 1'b1;
    src_req     = 4'b0001;
    pc          = 32'h600;
    push_exp(4'b0001, 32'h600);
    step();
    clear_in();
    step();
    eret        = 1'b1;
    instr_valid = 1'b1;
    src_req     = 4'b1000;
    pc          = 32'h700;
    @(negedge clk);
    total++;
    if (exc_taken !== 1'b0) begin
      bad++;
      $display("FAIL eret_prio_no_take: got taken=%b, expected 0", exc_taken);
    end
    step();
    eret = 1'b0;
    push_exp(4'b1000, 32'h700);
    @(negedge clk);
    total++;
    if (exc_taken !== 1'b1 || double_fault !== 1'b0 || in_handler !== 1'b0) begin
      bad++;
      $display("FAIL eret_prio_reissue: got taken=%b df=%b inh=%b, expected 1 0 0", exc_taken, double_fault, in_handler);
    end
    step();
    clear_in();
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    @(negedge clk);
    total++;
    if (double_fault !== 1'b0 || exc_count !== 8'd2) begin
      bad++;
      $display("FAIL eret_prio_final: got df=%b cnt=%0d, expected 0 2", double_fault, exc_count);
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    step();
    instr_valid = 1'b1;
    src_req     = 4'b0100;
    pc          = 32'h800;
    push_exp(4'b0100, 32'h800);
    step();
    clear_in();
    @(negedge clk);
    total++;
    if (flush !== 1'b1) begin
      bad++;
      $display("FAIL mid_flush_pre: got flush=%b, expected 1", flush);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({exc_taken, flush, cause, epc, in_handler, double_fault, exc_count} !== '0) begin
      bad++;
      $display("FAIL mid_flush_reset: got taken=%b flush=%b cause=%0d epc=%h inh=%b df=%b cnt=%0d, expected all 0",
               exc_taken, flush, cause, epc, in_handler, double_fault, exc_count);
    end
    step();
    rst     = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (exc_taken !== 1'b0 || flush !== 1'b0 || in_handler !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_quiet[%0d]: got taken=%b flush=%b inh=%b, expected 0 0 0",
                 i, exc_taken, flush, in_handler);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      run_exc(4'((i % 15) + 1), 32'(i * 4));
    end
    @(negedge clk);
    total++;
    if (exc_count !== 8'd255) begin
      bad++;
      $display("FAIL count_saturate: got %0d, expected 255", exc_count);
    end
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drained: got %0d pending, expected 0", sb.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    pc = '0;
    test_reset();
    test_basic();
    test_cause1();
    test_invalid();
    test_double_fault();
    test_reset_mid_flush();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
